reorder_buffer: RTL and testbench

Circular in-order reorder buffer for the RV32I out-of-order core. It sits between the instruction unit and the register file:
- Allocates one entry per issued instruction.
- Captures results from the common data bus (CDB).
- Answers operand-readiness lookups for the register file.
- Retires at most one instruction per cycle onto the register-file update port.
- Raises the pipeline flush on a mispredicted branch or jump.

---
 rtl/reorder_buffer_pkg.sv | 24 ++
 rtl/reorder_buffer.sv | 139 +++++++++++++
 tb/tb_reorder_buffer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer definitions: entry type encodings, default id width, per-entry record.
package reorder_buffer_pkg;

    localparam int ROB_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ROB_TYPE_REG    = 2'b00,
        ROB_TYPE_STORE  = 2'b01,
        ROB_TYPE_BRANCH = 2'b10,
        ROB_TYPE_JUMP   = 2'b11
    } rob_type_e;

    typedef struct packed {
        logic        busy;
        logic        ready;
        rob_type_e   robType;
        logic [4:0]  dest;
        logic [31:0] value;
        logic        predTaken;
        logic        actualTaken;
        logic [31:0] altPc;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocate on issue, capture CDB results, retire one per cycle.
// Latency: CDB result for the head retires with registered outputs on the following edge.
// Backpressure: robFull blocks issue; a freed slot is visible to issue one cycle after commit.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 issueValid,
    input  logic [1:0]           issueType,
    input  logic [4:0]           issueDest,
    input  logic                 issuePredTaken,
    input  logic [31:0]          issueAltPc,
    output logic [ROB_WIDTH-1:0] issueRobId,
    output logic                 robFull,
    input  logic                 cdbValid,
    input  logic [ROB_WIDTH-1:0] cdbRobId,
    input  logic [31:0]          cdbValue,
    input  logic                 cdbTaken,
    input  logic [ROB_WIDTH-1:0] robRs1Dep,
    input  logic [ROB_WIDTH-1:0] robRs2Dep,
    output logic                 robRs1Ready,
    output logic                 robRs2Ready,
    output logic [31:0]          robRs1Value,
    output logic [31:0]          robRs2Value,
    output logic                 regUpdateValid,
    output logic [4:0]           regUpdateDest,
    output logic [31:0]          regUpdateValue,
    output logic [ROB_WIDTH-1:0] regUpdateRobId,
    output logic                 storeCommitValid,
    output logic [ROB_WIDTH-1:0] storeCommitRobId,
    output logic                 clearOut,
    output logic [31:0]          newPcOut
);

    localparam int DEPTH = 1 << ROB_WIDTH;

    rob_entry_t           entries [DEPTH];
    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;

    rob_entry_t headEntry;
    logic       commitFire;
    logic       isCtrl;
    logic       mispredict;
    logic       writesRd;
    logic       isStore;
    logic       issueFire;
    logic       fwd1;
    logic       fwd2;

    assign robFull    = (count == (ROB_WIDTH+1)'(DEPTH));
    assign issueRobId = tail;

    always_comb begin
        headEntry  = entries[head];
        commitFire = headEntry.busy && headEntry.ready;
        isCtrl     = (headEntry.robType == ROB_TYPE_BRANCH) || (headEntry.robType == ROB_TYPE_JUMP);
        mispredict = commitFire && isCtrl && (headEntry.actualTaken != headEntry.predTaken);
        writesRd   = commitFire && (headEntry.dest != 5'd0) &&
                     ((headEntry.robType == ROB_TYPE_REG) || (headEntry.robType == ROB_TYPE_JUMP));
        isStore    = commitFire && (headEntry.robType == ROB_TYPE_STORE);
        issueFire  = issueValid && !robFull;
    end

    // Same-cycle CDB forwarding lets dependents wake without waiting for the array write.
    always_comb begin
        fwd1        = cdbValid && (cdbRobId == robRs1Dep);
        fwd2        = cdbValid && (cdbRobId == robRs2Dep);
        robRs1Ready = entries[robRs1Dep].busy && (entries[robRs1Dep].ready || fwd1);
        robRs2Ready = entries[robRs2Dep].busy && (entries[robRs2Dep].ready || fwd2);
        robRs1Value = fwd1 ? cdbValue : entries[robRs1Dep].value;
        robRs2Value = fwd2 ? cdbValue : entries[robRs2Dep].value;
    end

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            regUpdateValid   <= 1'b0;
            regUpdateDest    <= '0;
            regUpdateValue   <= '0;
            regUpdateRobId   <= '0;
            storeCommitValid <= 1'b0;
            storeCommitRobId <= '0;
            clearOut         <= 1'b0;
            newPcOut         <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            regUpdateValid   <= writesRd;
            regUpdateDest    <= writesRd ? headEntry.dest  : '0;
            regUpdateValue   <= writesRd ? headEntry.value : '0;
            regUpdateRobId   <= writesRd ? head            : '0;
            storeCommitValid <= isStore;
            storeCommitRobId <= isStore ? head : '0;
            clearOut         <= mispredict;
            newPcOut         <= mispredict ? headEntry.altPc : '0;

            if (mispredict) begin
                // Everything younger than the mispredicting entry is squashed, including this cycle's issue/CDB.
                head  <= '0;
                tail  <= '0;
                count <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    entries[i].busy <= 1'b0;
                end
            end else begin
                if (cdbValid && entries[cdbRobId].busy) begin
                    entries[cdbRobId].value       <= cdbValue;
                    entries[cdbRobId].actualTaken <= cdbTaken;
                    entries[cdbRobId].ready       <= 1'b1;
                end
                if (commitFire) begin
                    entries[head].busy <= 1'b0;
                    head               <= head + 1'b1;
                end
                if (issueFire) begin
                    entries[tail] <= '{busy:        1'b1,
                                       ready:       1'b0,
                                       robType:     rob_type_e'(issueType),
                                       dest:        issueDest,
                                       value:       32'd0,
                                       predTaken:   issuePredTaken,
                                       actualTaken: 1'b0,
                                       altPc:       issueAltPc};
                    tail <= tail + 1'b1;
                end
                count <= count + (ROB_WIDTH+1)'(issueFire) - (ROB_WIDTH+1)'(commitFire);
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with immediate-assertion checks against hand-computed values.
module tb_reorder_buffer;

    logic        clockIn;
    logic        resetIn;
    logic        issueValid;
    logic [1:0]  issueType;
    logic [4:0]  issueDest;
    logic        issuePredTaken;
    logic [31:0] issueAltPc;
    logic [3:0]  issueRobId;
    logic        robFull;
    logic        cdbValid;
    logic [3:0]  cdbRobId;
    logic [31:0] cdbValue;
    logic        cdbTaken;
    logic [3:0]  robRs1Dep;
    logic [3:0]  robRs2Dep;
    logic        robRs1Ready;
    logic        robRs2Ready;
    logic [31:0] robRs1Value;
    logic [31:0] robRs2Value;
    logic        regUpdateValid;
    logic [4:0]  regUpdateDest;
    logic [31:0] regUpdateValue;
    logic [3:0]  regUpdateRobId;
    logic        storeCommitValid;
    logic [3:0]  storeCommitRobId;
    logic        clearOut;
    logic [31:0] newPcOut;

    int total = 0;
    int bad   = 0;

    reorder_buffer #(.ROB_WIDTH(4)) dut (
        .clockIn(clockIn), .resetIn(resetIn),
        .issueValid(issueValid), .issueType(issueType), .issueDest(issueDest),
        .issuePredTaken(issuePredTaken), .issueAltPc(issueAltPc),
        .issueRobId(issueRobId), .robFull(robFull),
        .cdbValid(cdbValid), .cdbRobId(cdbRobId), .cdbValue(cdbValue), .cdbTaken(cdbTaken),
        .robRs1Dep(robRs1Dep), .robRs2Dep(robRs2Dep),
        .robRs1Ready(robRs1Ready), .robRs2Ready(robRs2Ready),
        .robRs1Value(robRs1Value), .robRs2Value(robRs2Value),
        .regUpdateValid(regUpdateValid), .regUpdateDest(regUpdateDest),
        .regUpdateValue(regUpdateValue), .regUpdateRobId(regUpdateRobId),
        .storeCommitValid(storeCommitValid), .storeCommitRobId(storeCommitRobId),
        .clearOut(clearOut), .newPcOut(newPcOut)
    );

    initial clockIn = 1'b0;
    always #5 clockIn = ~clockIn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clockIn);
        #1;
    endtask

    task automatic do_reset();
        resetIn = 1'b1;
        issueValid = 1'b0; issueType = 2'b00; issueDest = 5'd0;
        issuePredTaken = 1'b0; issueAltPc = 32'd0;
        cdbValid = 1'b0; cdbRobId = 4'd0; cdbValue = 32'd0; cdbTaken = 1'b0;
        robRs1Dep = 4'd0; robRs2Dep = 4'd0;
        tick();
        tick();
        resetIn = 1'b0;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] d, input logic p, input logic [31:0] alt);
        issueValid = 1'b1; issueType = t; issueDest = d; issuePredTaken = p; issueAltPc = alt;
        tick();
        issueValid = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] id, input logic [31:0] v, input logic tk);
        cdbValid = 1'b1; cdbRobId = id; cdbValue = v; cdbTaken = tk;
        tick();
        cdbValid = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_regUpdateValid", 32'(regUpdateValid), 32'd0);
        chk("rst_storeCommitValid", 32'(storeCommitValid), 32'd0);
        chk("rst_clearOut", 32'(clearOut), 32'd0);
        chk("rst_newPcOut", newPcOut, 32'd0);
        chk("rst_robFull", 32'(robFull), 32'd0);
        chk("rst_issueRobId", 32'(issueRobId), 32'd0);

        // Basic issue -> CDB -> commit
        issue(2'b00, 5'd5, 1'b0, 32'd0);
        cdb(4'd0, 32'h1234, 1'b0);
        chk("basic_no_early_commit", 32'(regUpdateValid), 32'd0);
        tick();
        chk("basic_valid", 32'(regUpdateValid), 32'd1);
        chk("basic_dest", 32'(regUpdateDest), 32'd5);
        chk("basic_value", regUpdateValue, 32'h1234);
        chk("basic_robid", 32'(regUpdateRobId), 32'd0);
        tick();
        chk("basic_pulse_one_cycle", 32'(regUpdateValid), 32'd0);

        // Fill to full, overflow issue ignored, freed slot usable only a cycle later
        do_reset();
        for (int i = 0; i < 16; i++) issue(2'b00, 5'(i + 1), 1'b0, 32'd0);
        chk("full_robFull", 32'(robFull), 32'd1);
        chk("full_tail_wrapped", 32'(issueRobId), 32'd0);
        issue(2'b00, 5'd9, 1'b0, 32'd0);
        chk("overflow_robFull", 32'(robFull), 32'd1);
        chk("overflow_tail_stays", 32'(issueRobId), 32'd0);
        cdb(4'd0, 32'h7, 1'b0);
        chk("full_still_full_before_commit", 32'(robFull), 32'd1);
        issue(2'b00, 5'd20, 1'b0, 32'd0);
        chk("commit_frees_robFull", 32'(robFull), 32'd0);
        chk("commit_frees_issueRobId", 32'(issueRobId), 32'd0);
        chk("full_commit_dest_not_overwritten", 32'(regUpdateDest), 32'd1);
        chk("full_commit_value", regUpdateValue, 32'h7);
        issue(2'b00, 5'd21, 1'b0, 32'd0);
        chk("refill_robFull", 32'(robFull), 32'd1);
        chk("refill_issueRobId", 32'(issueRobId), 32'd1);

        // Out-of-order completion, in-order retirement
        do_reset();
        issue(2'b00, 5'd1, 1'b0, 32'd0);
        issue(2'b00, 5'd2, 1'b0, 32'd0);
        issue(2'b00, 5'd3, 1'b0, 32'd0);
        cdb(4'd2, 32'h22, 1'b0);
        cdb(4'd1, 32'h11, 1'b0);
        chk("ooo_no_commit_without_head", 32'(regUpdateValid), 32'd0);
        cdb(4'd0, 32'h10, 1'b0);
        chk("ooo_head_same_cycle_no_commit", 32'(regUpdateValid), 32'd0);
        tick();
        chk("ooo_c0_valid", 32'(regUpdateValid), 32'd1);
        chk("ooo_c0_robid", 32'(regUpdateRobId), 32'd0);
        chk("ooo_c0_value", regUpdateValue, 32'h10);
        tick();
        chk("ooo_c1_robid", 32'(regUpdateRobId), 32'd1);
        chk("ooo_c1_value", regUpdateValue, 32'h11);
        tick();
        chk("ooo_c2_robid", 32'(regUpdateRobId), 32'd2);
        chk("ooo_c2_dest", 32'(regUpdateDest), 32'd3);
        chk("ooo_c2_value", regUpdateValue, 32'h22);
        tick();
        chk("ooo_done", 32'(regUpdateValid), 32'd0);

        // Operand lookup and CDB forwarding
        do_reset();
        for (int i = 0; i < 4; i++) issue(2'b00, 5'(i + 1), 1'b0, 32'd0);
        robRs1Dep = 4'd3; robRs2Dep = 4'd2;
        #1;
        chk("lookup_not_ready", 32'(robRs1Ready), 32'd0);
        cdbValid = 1'b1; cdbRobId = 4'd3; cdbValue = 32'hDEAD; cdbTaken = 1'b0;
        #1;
        chk("fwd_ready", 32'(robRs1Ready), 32'd1);
        chk("fwd_value", robRs1Value, 32'hDEAD);
        chk("fwd_other_port_not_ready", 32'(robRs2Ready), 32'd0);
        tick();
        cdbValid = 1'b0;
        #1;
        chk("stored_ready", 32'(robRs1Ready), 32'd1);
        chk("stored_value", robRs1Value, 32'hDEAD);
        robRs2Dep = 4'd5;
        #1;
        chk("nonbusy_not_ready", 32'(robRs2Ready), 32'd0);

        // Branch mispredict flush
        do_reset();
        issue(2'b10, 5'd0, 1'b0, 32'h100);
        issue(2'b00, 5'd6, 1'b0, 32'd0);
        issue(2'b00, 5'd7, 1'b0, 32'd0);
        cdb(4'd0, 32'd0, 1'b1);
        chk("flush_not_yet", 32'(clearOut), 32'd0);
        issueValid = 1'b1; issueType = 2'b00; issueDest = 5'd8;
        tick();
        issueValid = 1'b0;
        chk("flush_clearOut", 32'(clearOut), 32'd1);
        chk("flush_newPc", newPcOut, 32'h100);
        chk("flush_branch_no_regupdate", 32'(regUpdateValid), 32'd0);
        chk("flush_tail_reset", 32'(issueRobId), 32'd0);
        chk("flush_not_full", 32'(robFull), 32'd0);
        tick();
        chk("flush_pulse_one_cycle", 32'(clearOut), 32'd0);
        chk("flush_newPc_cleared", newPcOut, 32'd0);
        cdb(4'd1, 32'h55, 1'b0);
        robRs1Dep = 4'd1;
        #1;
        chk("flushed_cdb_ignored", 32'(robRs1Ready), 32'd0);
        tick();
        chk("flushed_no_commit", 32'(regUpdateValid), 32'd0);

        // Store commit, dest=0 REG, mispredicting JUMP still writes rd
        do_reset();
        issue(2'b01, 5'd0, 1'b0, 32'd0);
        issue(2'b00, 5'd0, 1'b0, 32'd0);
        issue(2'b00, 5'd4, 1'b0, 32'd0);
        issue(2'b11, 5'd3, 1'b0, 32'h200);
        cdb(4'd0, 32'h0, 1'b0);
        cdb(4'd1, 32'h55, 1'b0);
        chk("store_commit_valid", 32'(storeCommitValid), 32'd1);
        chk("store_commit_robid", 32'(storeCommitRobId), 32'd0);
        chk("store_no_regupdate", 32'(regUpdateValid), 32'd0);
        cdb(4'd2, 32'h66, 1'b0);
        chk("x0_no_regupdate", 32'(regUpdateValid), 32'd0);
        chk("x0_no_store", 32'(storeCommitValid), 32'd0);
        cdb(4'd3, 32'h44, 1'b1);
        chk("reg4_valid", 32'(regUpdateValid), 32'd1);
        chk("reg4_dest", 32'(regUpdateDest), 32'd4);
        chk("reg4_value", regUpdateValue, 32'h66);
        chk("reg4_robid", 32'(regUpdateRobId), 32'd2);
        tick();
        chk("jump_clearOut", 32'(clearOut), 32'd1);
        chk("jump_newPc", newPcOut, 32'h200);
        chk("jump_regupdate_valid", 32'(regUpdateValid), 32'd1);
        chk("jump_regupdate_dest", 32'(regUpdateDest), 32'd3);
        chk("jump_regupdate_value", regUpdateValue, 32'h44);
        chk("jump_regupdate_robid", 32'(regUpdateRobId), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
